dwell_driver: RTL

DWELL_DRIVER -- requirements
Module: dwell_driver

---
 rtl/dwell_driver_pkg.sv | 18 +
 rtl/dwell_cnt.sv | 28 ++
 rtl/dwell_driver.sv | 90 +++++++++
 3 files changed

// File: rtl/dwell_driver_pkg.sv
// Shared definitions for the line-driver and filter blocks: FSM encodings,
// the default base dwell and the dwell-length arithmetic.
package dwell_driver_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dwell_state_e;

  localparam int MIN_DWELL_DEFAULT = 10;
  localparam int HOLD_W            = 4;

  // Total dwell in cycles; evaluated as int so 16*16 cannot overflow.
  function automatic int dwellCycles(input int minDwell, input logic [HOLD_W-1:0] hold);
    return minDwell * (int'(hold) + 1);
  endfunction

endpackage

// File: rtl/dwell_cnt.sv
// Loadable down-counter that stops at zero and flags when it gets there.
module dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] loadVal,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; the count saturates at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dwell_driver.sv
// Drives a line level that, once changed, is held for a programmable dwell so
// every level survives a downstream 8-cycle input filter.
module dwell_driver
  import dwell_driver_pkg::*;
#(
  parameter int MIN_DWELL = MIN_DWELL_DEFAULT,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_level,
  input  logic [HOLD_W-1:0] req_hold,
  output logic              req_ready,
  output logic              q,
  output logic              busy,
  output logic              done
);

  dwell_state_e     state, stateNext;
  logic             qNext;
  logic             doneNext;
  logic             cntLoad;
  logic             cntDec;
  logic             cntZero;
  logic [CNT_W-1:0] loadVal;

  // Counter holds D-1 so the transition out of HOLD lands on edge k+D.
  assign loadVal = CNT_W'(dwellCycles(MIN_DWELL, req_hold) - 1);

  dwell_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cntLoad),
    .dec    (cntDec),
    .loadVal(loadVal),
    .zero   (cntZero)
  );

  assign req_ready = (state == IDLE) && rst_n;
  assign busy      = (state == HOLD);

  always_comb begin
    stateNext = state;
    qNext     = q;
    doneNext  = 1'b0;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_level != q) begin
            qNext     = req_level;
            cntLoad   = 1'b1;
            stateNext = HOLD;
          end else begin
            doneNext = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cntZero) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else begin
          cntDec = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Reset parks the line high and discards any dwell without signalling done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      q     <= qNext;
      done  <= doneNext;
    end
  end

endmodule
